seq_shifter32: RTL and testbench
================================

// Module: seq_shifter32
//
// PURPOSE
//   Multi-cycle 32-bit shift unit for the R-type datapath: SLL/SRL/SRA (optional ROR).
//   Sits directly downstream of the 5->32-bit shamt zero-extender.
//   Consumes the zero-extended shift amount and the rt operand.
//   Shifts STEP bits per cycle, then returns the result with a one-cycle done pulse.
//
// PARAMETERS
//   STEP_LOG2  0  log2 of bits shifted per cycle; legal 0..2 (STEP = 1, 2 or 4)
//
// PORTS
//   clk       in   1   single clock, rising edge
//   rst_n     in   1   asynchronous, active-low reset
//   start_i   in   1   request; accepted only when busy_o=0
//   op_i      in   2   00 SLL, 01 SRL, 10 SRA, 11 ROR (see CONFIGURATION)
//   data_i    in   32  operand to shift (rt)
//   shamt_i   in   32  zero-extended shift amount; only bits [4:0] used
//   result_o  out  32  shifted result; valid when done_o=1, then held
//   done_o    out  1   one-cycle pulse, result_o valid
//   busy_o    out  1   high from acceptance until the done cycle inclusive
//
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, result_o=0, done_o=0, busy_o=0, count=0.
//   - FSM states:
//     - IDLE:  on start_i -> latch data, op, n=shamt_i[4:0], sign=data_i[31].
//              Go to SHIFT if n!=0, else DONE.
//     - SHIFT: each edge shift by k=min(n,STEP) and set n-=k; go to DONE when n reaches 0.
//     - DONE:  done_o=1 for exactly this cycle; next edge -> IDLE.
//   - Latency, acceptance edge to done cycle: 1 + ceil(n/STEP) cycles.
//     - n=0: done_o in the cycle after acceptance.
//     - n=31, STEP=1: done 32 cycles after acceptance.
//   - Fill rules:
//     - SLL shifts in 0 at bit 0.
//     - SRL shifts in 0 at bit 31.
//     - SRA shifts in the latched sign bit.
//   - shamt_i[31:5] nonzero: ignored (MIPS semantics, amount is mod 32). No error.
//   - start_i while busy_o=1 (SHIFT or DONE): ignored and not queued; inputs not sampled.
//   - result_o and the working register are the same register.
//     - It changes only while shifting.
//     - It holds the final value after DONE until the next acceptance.
//   - Reset asserted mid-operation: aborts immediately, no done_o pulse, outputs return to reset values.
//   - done_o and busy_o are registered (driven from state), with no combinational path from inputs.
//
// CONFIGURATION
//   SEQ_SHIFTER_ROR_EN defined: op 11 = rotate right by n; bits leaving bit 0 re-enter at bit 31.
//     Same latency as the other ops.
//   SEQ_SHIFTER_ROR_EN undefined: op 11 = no-op; result_o=data_i and latency 1,
//     regardless of shamt_i.
//
// STRUCTURE
//   seq_shift_pkg: OP_SLL/OP_SRL/OP_SRA/OP_ROR encodings, FSM state encodings
//     (S_IDLE/S_SHIFT/S_DONE), STEP derivation constant.
//   Sub-module shift_step32: purely combinational one-step shifter.
//     Inputs: 32-bit value, op, fill bit, k (0..STEP).
//     Instanced once inside the SHIFT datapath.
//   Top level holds the FSM, counter, and result/op/sign registers only.
//
// TESTING
//   1. SLL, data=0x0000_0001, shamt=0x0000_0004, STEP=1
//      -> result=0x0000_0010; done pulse 5 cycles after acceptance, busy high through it.
//   2. SRA, data=0x8000_0000, shamt=31
//      -> result=0xFFFF_FFFF. SRL of the same data -> result=0x0000_0001.
//   3. shamt=0 with any op (data=0xDEAD_BEEF)
//      -> result=0xDEAD_BEEF; done 1 cycle after acceptance.
//   4. shamt=0x0000_0021 (upper bits set), SLL on 0x1
//      -> shift by 1, result=0x0000_0002.
//   5. start pulsed every cycle during an operation
//      -> only the first accepted; one done per accepted request.
//      rst_n low mid-SHIFT -> done never pulses; result_o=0.
//   6. op=11, data=0x0000_0003, shamt=1
//      -> ROR_EN: result=0x8000_0001 after 2 cycles.
//      -> otherwise: result=0x0000_0003 after 1 cycle.
//      Repeat tests 1-2 at STEP_LOG2=2 for latency 1+ceil(n/4).

Source files
------------

// File: rtl/seq_shift_pkg.sv
// Shared encodings for the sequential 32-bit shifter: op codes, FSM states, step size.
package seq_shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Largest supported step is 4 bits per cycle, so a step count fits in 3 bits.
    localparam int STEP_LOG2_MAX = 2;

    function automatic int step_of(input int step_log2);
        return 1 << step_log2;
    endfunction

endpackage

// File: rtl/shift_step32.sv
// Combinational single-step shifter: moves a 32-bit value by k (0..4) bits for SLL/SRL/SRA/ROR.
module shift_step32
    import seq_shift_pkg::*;
(
    input  logic [31:0] value,
    input  logic [1:0]  op,
    input  logic        fill,
    input  logic [2:0]  k,
    output logic [31:0] shifted
);

    logic [63:0] wide;

    // Right shifts run over a 64-bit word so the upper half supplies fill or wrap bits.
    always_comb begin
        wide    = '0;
        shifted = value;
        case (op)
            OP_SLL: shifted = value << k;
            OP_SRL, OP_SRA: begin
                wide    = {{32{fill}}, value} >> k;
                shifted = wide[31:0];
            end
            default: begin
                wide    = {value, value} >> k;
                shifted = wide[31:0];
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter32.sv
// Multi-cycle 32-bit shifter (SLL/SRL/SRA, STEP bits per cycle) with a one-cycle done pulse.
// Define SEQ_SHIFTER_ROR_EN to make op 11 a rotate right; otherwise op 11 is a 1-cycle no-op.
module seq_shifter32
    import seq_shift_pkg::*;
#(
    parameter int STEP_LOG2 = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] data_i,
    input  logic [31:0] shamt_i,
    output logic [31:0] result_o,
    output logic        done_o,
    output logic        busy_o
);

    localparam int STEP = step_of(STEP_LOG2);

    state_t      state;
    logic [4:0]  count;
    logic [1:0]  op_q;
    logic        sign_q;
    logic [2:0]  k;
    logic        fill;
    logic        go_shift;
    logic [31:0] stepped;
    logic        shamt_hi_unused;

    // Amount is taken mod 32, so the upper shamt bits are intentionally dropped.
    assign shamt_hi_unused = ^shamt_i[31:5];

    always_comb begin
`ifdef SEQ_SHIFTER_ROR_EN
        go_shift = (shamt_i[4:0] != 5'd0);
`else
        go_shift = (shamt_i[4:0] != 5'd0) && (op_i != OP_ROR);
`endif
    end

    always_comb begin
        k    = (count < 5'(STEP)) ? count[2:0] : 3'(STEP);
        fill = (op_q == OP_SRA) ? sign_q : 1'b0;
    end

    shift_step32 u_step (
        .value   (result_o),
        .op      (op_q),
        .fill    (fill),
        .k       (k),
        .shifted (stepped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            result_o <= '0;
            done_o   <= 1'b0;
            busy_o   <= 1'b0;
            count    <= '0;
            op_q     <= OP_SLL;
            sign_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        result_o <= data_i;
                        op_q     <= op_i;
                        sign_q   <= data_i[31];
                        busy_o   <= 1'b1;
                        if (go_shift) begin
                            count <= shamt_i[4:0];
                            state <= S_SHIFT;
                        end else begin
                            count  <= '0;
                            done_o <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    result_o <= stepped;
                    count    <= count - 5'(k);
                    // Last partial or full step lands directly in DONE.
                    if (count == 5'(k)) begin
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter32.sv
// Bench for seq_shifter32: STEP=1 and STEP=4 instances share stimulus and are checked each cycle
// against an arithmetic model, plus directed vectors with hand-computed results and latencies.
module tb_seq_shifter32;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] data = '0;
    logic [31:0] shamt = '0;

    logic [31:0] res_a  [2];
    logic        done_a [2];
    logic        busy_a [2];

    int n_checks = 0;
    int n_fail   = 0;
    int step_a [2] = '{1, 4};

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    seq_shifter32 #(.STEP_LOG2(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .data_i(data),
        .shamt_i(shamt), .result_o(res_a[0]), .done_o(done_a[0]), .busy_o(busy_a[0])
    );

    seq_shifter32 #(.STEP_LOG2(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .data_i(data),
        .shamt_i(shamt), .result_o(res_a[1]), .done_o(done_a[1]), .busy_o(busy_a[1])
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] d,
                                               input logic [31:0] s);
        logic [4:0] n;
        n = s[4:0];
        case (o)
            SLL: return d << n;
            SRL: return d >> n;
            SRA: return $unsigned($signed(d) >>> n);
            default: begin
`ifdef SEQ_SHIFTER_ROR_EN
                return (d >> n) | (d << (6'd32 - {1'b0, n}));
`else
                return d;
`endif
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] s, input int step);
        int n;
        n = int'(s[4:0]);
`ifndef SEQ_SHIFTER_ROR_EN
        if (o == ROR) return 1;
`endif
        return 1 + (n + step - 1) / step;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle scoreboard ----------------
    logic        m_act [2] = '{1'b0, 1'b0};
    int          m_rem [2] = '{0, 0};
    logic [31:0] m_res [2] = '{32'h0, 32'h0};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_act[d] = 1'b0;
                m_rem[d] = 0;
                m_res[d] = '0;
            end else if (m_act[d]) begin
                if (m_rem[d] == 0) m_act[d] = 1'b0;
                else m_rem[d] = m_rem[d] - 1;
            end else if (start) begin
                m_act[d] = 1'b1;
                m_res[d] = ref_result(op, data, shamt);
                m_rem[d] = ref_latency(op, shamt, step_a[d]) - 1;
            end
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy[%0d]", d), {31'b0, busy_a[d]}, {31'b0, m_act[d]});
            chk($sformatf("done[%0d]", d), {31'b0, done_a[d]}, {31'b0, m_act[d] && m_rem[d] == 0});
            if (!m_act[d] || m_rem[d] == 0)
                chk($sformatf("result[%0d]", d), res_a[d], m_res[d]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] d,
                          input logic [31:0] s, input logic [31:0] exp_res,
                          input int exp_lat1, input int exp_lat4);
        int          lat [2];
        logic [31:0] got [2];
        lat[0] = 0; lat[1] = 0;
        got[0] = '0; got[1] = '0;
        @(negedge clk);
        op = o; data = d; shamt = s; start = 1'b1;
        for (int cyc = 1; cyc <= 100 && (lat[0] == 0 || lat[1] == 0); cyc++) begin
            @(posedge clk);
            #3;
            start = 1'b0;
            for (int dd = 0; dd < 2; dd++) begin
                if (lat[dd] == 0 && done_a[dd]) begin
                    lat[dd] = cyc;
                    got[dd] = res_a[dd];
                end
            end
        end
        chk({name, " lat step1"}, lat[0], exp_lat1);
        chk({name, " lat step4"}, lat[1], exp_lat4);
        chk({name, " res step1"}, got[0], exp_res);
        chk({name, " res step4"}, got[1], exp_res);
        @(posedge clk);
    endtask

    task automatic spam_start();
        @(negedge clk);
        op = SLL; data = 32'h1; shamt = 32'd3; start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            data  = data + 32'd1;
            shamt = 32'(i % 7);
            op    = 2'(i % 3);
        end
        start = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic reset_mid_shift();
        @(negedge clk);
        op = SLL; data = 32'h1; shamt = 32'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("abort result[%0d]", d), res_a[d], 32'h0);
            chk($sformatf("abort busy[%0d]", d), {31'b0, busy_a[d]}, 32'h0);
            chk($sformatf("abort done[%0d]", d), {31'b0, done_a[d]}, 32'h0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset result[%0d]", d), res_a[d], 32'h0);
            chk($sformatf("reset busy[%0d]", d), {31'b0, busy_a[d]}, 32'h0);
            chk($sformatf("reset done[%0d]", d), {31'b0, done_a[d]}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sll1by4",   SLL, 32'h0000_0001, 32'd4,  32'h0000_0010, 5, 2);
        run_op("sra31",     SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32, 9);
        run_op("srl31",     SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 32, 9);
        run_op("sll0",      SLL, 32'hDEAD_BEEF, 32'd0,  32'hDEAD_BEEF, 1, 1);
        run_op("srl0",      SRL, 32'hDEAD_BEEF, 32'd0,  32'hDEAD_BEEF, 1, 1);
        run_op("sra0",      SRA, 32'hDEAD_BEEF, 32'd0,  32'hDEAD_BEEF, 1, 1);
        run_op("ror0",      ROR, 32'hDEAD_BEEF, 32'd0,  32'hDEAD_BEEF, 1, 1);
        run_op("sllhi",     SLL, 32'h0000_0001, 32'h21, 32'h0000_0002, 2, 2);
        run_op("sra4",      SRA, 32'hF000_0000, 32'd4,  32'hFF00_0000, 5, 2);
        run_op("srl4",      SRL, 32'hF000_0000, 32'd4,  32'h0F00_0000, 5, 2);
        run_op("sll5",      SLL, 32'h0000_0003, 32'd5,  32'h0000_0060, 6, 3);
`ifdef SEQ_SHIFTER_ROR_EN
        run_op("ror1",      ROR, 32'h0000_0003, 32'd1,  32'h8000_0001, 2, 2);
        run_op("ror8",      ROR, 32'h1234_5678, 32'd8,  32'h7812_3456, 9, 3);
`else
        run_op("ror1",      ROR, 32'h0000_0003, 32'd1,  32'h0000_0003, 1, 1);
        run_op("ror8",      ROR, 32'h1234_5678, 32'd8,  32'h1234_5678, 1, 1);
`endif

        spam_start();
        reset_mid_shift();
        run_op("after_rst", SRA, 32'h8000_0010, 32'd2,  32'hE000_0004, 3, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
